// File: rtl/fright_timer.sv
// Frightened-mode timer: counts fright and flash time, and issues the reversal
// pulse, the expiry pulse and the escalating ghost-eat score values.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   fright_time         seconds of fright (sampled on pellet)
//   fright_flashes      flash count (sampled on pellet)
//   pellet_eaten        trigger pulse
//   ghost_eaten         frightened ghost caught
//   pause               freezes timers
//   frightened          ghosts in frightened mode
//   flash_white         draw frightened ghosts white
//   ghost_reverse       one-cycle reversal pulse
//   fright_done         one-cycle natural expiry pulse
//   ghost_points        last ghost score
//   ghost_points_valid  qualifies ghost_points
module fright_timer #(
  parameter int SEC_CYCLES        = 25000000,
  parameter int FLASH_HALF_CYCLES = 5000000,
  parameter int CNT_W             = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fright_time,
  input  logic [2:0]  fright_flashes,
  input  logic        pellet_eaten,
  input  logic        ghost_eaten,
  input  logic        pause,
  output logic        frightened,
  output logic        flash_white,
  output logic        ghost_reverse,
  output logic        fright_done,
  output logic [11:0] ghost_points,
  output logic        ghost_points_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLUE  = 2'd1,
    FLASH = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] SEC_C  = CNT_W'(SEC_CYCLES);
  localparam logic [CNT_W-1:0] FLW_C  = CNT_W'(2 * FLASH_HALF_CYCLES);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(FLASH_HALF_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             flash_q, flash_d;
  logic [1:0]       combo_q, combo_d;
  logic             rev_q, rev_d;
  logic             done_q, done_d;
  logic [11:0]      pts_q, pts_d;
  logic             pv_q, pv_d;

  logic [CNT_W-1:0] t_new, w_new;
  logic [CNT_W-1:0] rem_dec, ph_dec;

  assign t_new   = {{(CNT_W-4){1'b0}}, fright_time} * SEC_C;
  assign w_new   = {{(CNT_W-3){1'b0}}, fright_flashes} * FLW_C;
  assign rem_dec = remain_q - 1'b1;
  assign ph_dec  = phase_q - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      win_q    <= '0;
      phase_q  <= '0;
      flash_q  <= 1'b0;
      combo_q  <= 2'd0;
      rev_q    <= 1'b0;
      done_q   <= 1'b0;
      pts_q    <= 12'd0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      win_q    <= win_d;
      phase_q  <= phase_d;
      flash_q  <= flash_d;
      combo_q  <= combo_d;
      rev_q    <= rev_d;
      done_q   <= done_d;
      pts_q    <= pts_d;
      pv_q     <= pv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    win_d    = win_q;
    phase_d  = phase_q;
    flash_d  = flash_q;
    combo_d  = combo_q;
    rev_d    = 1'b0;
    done_d   = 1'b0;
    pts_d    = pts_q;
    pv_d     = 1'b0;
    if (pellet_eaten) begin
      // trigger overrides everything, including a same-cycle expiry
      remain_d = t_new;
      win_d    = w_new;
      combo_d  = 2'd0;
      rev_d    = 1'b1;
      phase_d  = HALF_C;
      if (t_new == '0) begin
        state_d = IDLE;
        flash_d = 1'b0;
      end else if (w_new >= t_new) begin
        state_d = FLASH;
        flash_d = 1'b1;
      end else begin
        state_d = BLUE;
        flash_d = 1'b0;
      end
      // same-cycle ghost sees the freshly reset combo
      if (ghost_eaten && (t_new != '0)) begin
        pts_d   = 12'd200;
        pv_d    = 1'b1;
        combo_d = 2'd1;
      end
    end else if (state_q != IDLE) begin
      if (ghost_eaten) begin
        pts_d   = 12'd200 << combo_q;
        pv_d    = 1'b1;
        combo_d = (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
      end
      if (!pause) begin
        remain_d = rem_dec;
        if (rem_dec == '0) begin
          state_d = IDLE;
          flash_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          unique case (state_q)
            BLUE: begin
              if ((win_q != '0) && (rem_dec <= win_q)) begin
                state_d = FLASH;
                flash_d = 1'b1;
                phase_d = HALF_C;
              end
            end
            FLASH: begin
              if (ph_dec == '0) begin
                flash_d = ~flash_q;
                phase_d = HALF_C;
              end else begin
                phase_d = ph_dec;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    frightened         = (state_q != IDLE);
    flash_white        = flash_q;
    ghost_reverse      = rev_q;
    fright_done        = done_q;
    ghost_points       = pts_q;
    ghost_points_valid = pv_q;
  end

endmodule
